// File: rtl/sci_frame_detect_pkg.sv
// Shared SCI definitions: frame-detector state encoding, default sync
// header bytes and the frame-status codes used to decode the close pulses.
package sci_frame_detect_pkg;

  // One-hot state encoding; the IDLE bit alone identifies "not busy".
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_HDR  = 5'b00010,
    S_LEN  = 5'b00100,
    S_PAY  = 5'b01000,
    S_CHK  = 5'b10000
  } sci_state_t;

  localparam logic [7:0] SCI_HDR0 = 8'hEB;
  localparam logic [7:0] SCI_HDR1 = 8'h90;

  // Reason a frame was closed; qualifies the end_instr pulse.
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_CHK_ERR = 2'd1;
  localparam logic [1:0] ST_LEN_ERR = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

endpackage

// File: rtl/sci_frame_detect_gap_timer.sv
// sci_gap_timer: inter-byte idle counter for the SCI frame detector.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_clear     zero the counter (byte received or detector idle)
//   i_run       count one cycle
//   o_expire    high in the cycle whose edge completes GAP_CYC idle cycles
module sci_gap_timer #(
  parameter int GAP_CYC = 5000,
  parameter int GAP_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam logic [GAP_W-1:0] LAST_CNT = GAP_W'(GAP_CYC - 1);

  logic [GAP_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + GAP_W'(1);
    end
  end

  // A clear in the same cycle (byte arriving) suppresses expiry.
  assign o_expire = i_run && !i_clear && (r_cnt == LAST_CNT);

endmodule

// File: rtl/sci_frame_detect.sv
// sci_frame_detect: frames SCI instructions in the received UART byte
// stream (HDR0 HDR1 LEN P[0..LEN-1] CHK, CHK = LEN + sum P mod 256) and
// pulses new_instr / end_instr for the ping-pong bank controller.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        detector enable; low forces IDLE silently
//   rx_valid      one-cycle strobe qualifying rx_data
//   rx_data       received byte
//   new_instr     pulse: header complete
//   end_instr     pulse: frame closed, qualified by exactly one of
//   frame_ok / chk_err / len_err / gap_timeout
//   payload_len   LEN of the current/last legal frame
//   busy          detector is not IDLE
module sci_frame_detect
  import sci_frame_detect_pkg::*;
#(
  parameter logic [7:0] HDR0    = SCI_HDR0,
  parameter logic [7:0] HDR1    = SCI_HDR1,
  parameter logic [7:0] MAX_LEN = 8'd64,
  parameter int         GAP_CYC = 5000,
  parameter int         GAP_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       new_instr,
  output logic       end_instr,
  output logic       frame_ok,
  output logic       chk_err,
  output logic       len_err,
  output logic       gap_timeout,
  output logic [7:0] payload_len,
  output logic       busy
);

  sci_state_t r_state, w_state_nxt;
  logic [7:0] r_acc, w_acc_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_len, w_len_nxt;
  logic       w_new_nxt, w_end_nxt;
  logic [1:0] w_status;
  logic       r_new, r_end, r_ok, r_chk_err, r_len_err, r_gap;
  logic       w_busy, w_gap_clear, w_gap_expire;

  assign w_busy      = (r_state != S_IDLE);
  assign w_gap_clear = !w_busy || rx_valid || !enable;

  sci_gap_timer #(
    .GAP_CYC (GAP_CYC),
    .GAP_W   (GAP_W)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_gap_clear),
    .i_run    (w_busy),
    .o_expire (w_gap_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_new_nxt   = 1'b0;
    w_end_nxt   = 1'b0;
    w_status    = ST_OK;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else if (rx_valid) begin
      // A received byte always takes priority over gap expiry.
      unique case (r_state)
        S_IDLE: begin
          if (rx_data == HDR0) w_state_nxt = S_HDR;
        end
        S_HDR: begin
          if (rx_data == HDR1) begin
            w_state_nxt = S_LEN;
            w_new_nxt   = 1'b1;
          end else if (rx_data != HDR0) begin
            w_state_nxt = S_IDLE;
          end
        end
        S_LEN: begin
          if ((rx_data != 8'd0) && (rx_data <= MAX_LEN)) begin
            w_state_nxt = S_PAY;
            w_len_nxt   = rx_data;
            w_acc_nxt   = rx_data;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_state_nxt = S_IDLE;
            w_end_nxt   = 1'b1;
            w_status    = ST_LEN_ERR;
          end
        end
        S_PAY: begin
          w_acc_nxt = r_acc + rx_data;
          w_cnt_nxt = r_cnt + 8'd1;
          if (r_cnt == r_len - 8'd1) w_state_nxt = S_CHK;
        end
        S_CHK: begin
          w_state_nxt = S_IDLE;
          w_end_nxt   = 1'b1;
          w_status    = (rx_data == r_acc) ? ST_OK : ST_CHK_ERR;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_gap_expire) begin
      w_state_nxt = S_IDLE;
      w_end_nxt   = 1'b1;
      w_status    = ST_GAP;
    end
  end

  // Registered datapath and status pulses, decoded from the close reason.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= 8'd0;
      r_cnt     <= 8'd0;
      r_len     <= 8'd0;
      r_new     <= 1'b0;
      r_end     <= 1'b0;
      r_ok      <= 1'b0;
      r_chk_err <= 1'b0;
      r_len_err <= 1'b0;
      r_gap     <= 1'b0;
    end else begin
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_len     <= w_len_nxt;
      r_new     <= w_new_nxt;
      r_end     <= w_end_nxt;
      r_ok      <= w_end_nxt && (w_status == ST_OK);
      r_chk_err <= w_end_nxt && (w_status == ST_CHK_ERR);
      r_len_err <= w_end_nxt && (w_status == ST_LEN_ERR);
      r_gap     <= w_end_nxt && (w_status == ST_GAP);
    end
  end

  assign new_instr   = r_new;
  assign end_instr   = r_end;
  assign frame_ok    = r_ok;
  assign chk_err     = r_chk_err;
  assign len_err     = r_len_err;
  assign gap_timeout = r_gap;
  assign payload_len = r_len;
  assign busy        = w_busy;

endmodule
